// File: rtl/chess_pkg.sv
// Shared definitions for the chess-lab board reader: geometry and FSM state codes.
package chess_pkg;

  localparam int N_LINHAS  = 8;
  localparam int N_COLUNAS = 8;
  localparam int N_QUAD    = N_LINHAS * N_COLUNAS;

  typedef enum logic [3:0] {
    ST_VARRE  = 4'd1,
    ST_AVALIA = 4'd2,
    ST_EMITE  = 4'd3
  } estado_t;

  // Board coordinates leave the reader 1-based (rank 1..8, file 1..8 with 1 = A).
  function automatic logic [3:0] coord(input logic [2:0] indice);
    return {1'b0, indice} + 4'd1;
  endfunction

endpackage

// File: rtl/leitor_tabuleiro_if.sv
// Board-side and game-side signals of the square-sensor reader.
interface leitor_tabuleiro_if;
  import chess_pkg::*;

  logic                 habilita;
  logic [N_COLUNAS-1:0] colunas_in;
  logic [N_LINHAS-1:0]  linhas_out;
  logic [3:0]           jogadaFileira;
  logic [3:0]           jogadaColuna;
  logic                 temJogada;
  logic                 erroMulti;
  logic [3:0]           db_estado;
  logic [2:0]           db_linha;

  // master: the reader itself; slave: the sensor matrix and game logic around it.
  modport master (
    input  habilita, colunas_in,
    output linhas_out, jogadaFileira, jogadaColuna, temJogada, erroMulti,
           db_estado, db_linha
  );

  modport slave (
    output habilita, colunas_in,
    input  linhas_out, jogadaFileira, jogadaColuna, temJogada, erroMulti,
           db_estado, db_linha
  );

endinterface

// File: rtl/leitor_tabuleiro_codificador_quadrado.sv
// Turns the image of newly pressed squares into one square index plus
// single/multiple-press flags.
module codificador_quadrado
  import chess_pkg::*;
(
  input  logic [N_QUAD-1:0] novo,
  output logic [2:0]        linha,
  output logic [2:0]        coluna,
  output logic              unico,
  output logic              multiplo
);

  logic [1:0] cont;
  logic [5:0] idx;

  // Count saturates at 2: only "none / one / more than one" matters downstream.
  always_comb begin
    cont = 2'd0;
    idx  = 6'd0;
    for (int i = 0; i < N_QUAD; i++) begin
      if (novo[i]) begin
        idx = 6'(i);
        if (cont != 2'd2) cont = cont + 2'd1;
      end
    end
  end

  assign linha    = idx[5:3];
  assign coluna   = idx[2:0];
  assign unico    = (cont == 2'd1);
  assign multiplo = (cont == 2'd2);

endmodule

// File: rtl/leitor_tabuleiro.sv
// 8x8 sensor-matrix scanner: row-by-row scan, whole-frame debounce and
// detection of one newly pressed square per accepted frame.
module leitor_tabuleiro
  import chess_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              clock,
  input  logic              reset,
  leitor_tabuleiro_if.master bus
);

  localparam int SW = $clog2(SETTLE);
  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0]       ESPERA_FIM = SW'(SETTLE - 1);
  localparam logic [CW-1:0]       QUADROS    = CW'(STABLE_FRAMES);
  localparam logic [N_LINHAS-1:0] LINHA0     = N_LINHAS'(1);

  estado_t           estado;
  estado_t           proximo;
  logic [2:0]        linha;
  logic [SW-1:0]     espera;
  logic [N_QUAD-1:0] bruto;
  logic [N_QUAD-1:0] ultimo;
  logic [N_QUAD-1:0] aceito;
  logic [CW-1:0]     estaveis;
  logic [CW-1:0]     estaveis_prox;
  logic              base;
  logic [3:0]        fileira;
  logic [3:0]        coluna;

  logic              fim_espera;
  logic              iguais;
  logic              aceita;
  logic              tem;
  logic              erro;
  logic [N_QUAD-1:0] novo;
  logic [2:0]        lin_novo;
  logic [2:0]        col_novo;
  logic              unico;
  logic              multiplo;

  assign fim_espera = (espera == ESPERA_FIM);
  assign iguais     = (bruto == ultimo);
  assign novo       = bruto & ~aceito;

  always_comb begin
    if (!iguais)
      estaveis_prox = CW'(1);
    else if (estaveis == QUADROS)
      estaveis_prox = QUADROS;
    else
      estaveis_prox = estaveis + CW'(1);
  end

  // Acceptance fires only on the frame where the count first reaches the
  // target, so a board held still is reported once, not every frame.
  assign aceita = (estaveis_prox == QUADROS)
               && !(iguais && (estaveis == QUADROS))
               && (bruto != aceito);

  codificador_quadrado u_codificador (
    .novo     (novo),
    .linha    (lin_novo),
    .coluna   (col_novo),
    .unico    (unico),
    .multiplo (multiplo)
  );

  always_ff @(posedge clock) begin
    if (reset) estado <= ST_VARRE;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    tem     = 1'b0;
    erro    = 1'b0;
    unique case (estado)
      ST_VARRE: begin
        if (fim_espera && (linha == 3'd7)) proximo = ST_AVALIA;
      end
      ST_AVALIA: begin
        proximo = aceita ? ST_EMITE : ST_VARRE;
      end
      ST_EMITE: begin
        proximo = ST_VARRE;
        tem     = !base && unico    && bus.habilita;
        erro    = !base && multiplo && bus.habilita;
      end
      default: proximo = ST_VARRE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      linha    <= 3'd0;
      espera   <= '0;
      bruto    <= '0;
      ultimo   <= '0;
      aceito   <= '0;
      estaveis <= '0;
      base     <= 1'b1;
      fileira  <= 4'd0;
      coluna   <= 4'd0;
    end else begin
      unique case (estado)
        ST_VARRE: begin
          // Row index wraps 7 -> 0, so row 0 is already driven during AVALIA/EMITE.
          if (fim_espera) begin
            espera                            <= '0;
            bruto[{linha, 3'b000} +: N_COLUNAS] <= bus.colunas_in;
            linha                             <= linha + 3'd1;
          end else begin
            espera <= espera + SW'(1);
          end
        end
        ST_AVALIA: begin
          estaveis <= estaveis_prox;
          if (!iguais) ultimo <= bruto;
        end
        ST_EMITE: begin
          aceito <= bruto;
          base   <= 1'b0;
          if (tem) begin
            fileira <= coord(lin_novo);
            coluna  <= coord(col_novo);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.linhas_out    = LINHA0 << linha;
  assign bus.temJogada     = tem;
  assign bus.erroMulti     = erro;
  assign bus.jogadaFileira = tem ? coord(lin_novo) : fileira;
  assign bus.jogadaColuna  = tem ? coord(col_novo) : coluna;
  assign bus.db_estado     = estado;
  assign bus.db_linha      = linha;

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Directed bench for leitor_tabuleiro: a sensor-matrix model plus a scoreboard
// of expected move/error pulses checked by an independent monitor.
module tb_leitor_tabuleiro;
  import chess_pkg::*;

  localparam int SETTLE        = 4;
  localparam int STABLE_FRAMES = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] board = '0;

  always #5 clock = ~clock;

  leitor_tabuleiro_if bus ();

  leitor_tabuleiro #(
    .SETTLE        (SETTLE),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Sensor matrix: a pressed square pulls its column only while its row is driven.
  always_comb begin
    bus.colunas_in = '0;
    for (int r = 0; r < 8; r++)
      if (bus.linhas_out[r]) bus.colunas_in = bus.colunas_in | board[r*8 +: 8];
  end

  typedef struct {
    bit         multi;
    logic [3:0] f;
    logic [3:0] c;
    int         mark;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   aval_cnt   = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clock)
    if (!reset && bus.db_estado == 4'd2) aval_cnt++;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (bus.temJogada || bus.erroMulti) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: tem=%b erro=%b fileira=%0d coluna=%0d, expected no pulse",
                   bus.temJogada, bus.erroMulti, bus.jogadaFileira, bus.jogadaColuna);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {bus.erroMulti, bus.temJogada}, e.multi ? 2'b10 : 2'b01);
          check("pulse_fileira", bus.jogadaFileira, e.f);
          check("pulse_coluna", bus.jogadaColuna, e.c);
          check("pulse_latency_frames", aval_cnt - e.mark, STABLE_FRAMES);
          check("pulse_state", bus.db_estado, 4'd3);
        end
        check("pulse_width", prev_pulse, 1'b0);
      end
      prev_pulse = bus.temJogada || bus.erroMulti;
    end
  end

  task automatic wait_avalia();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.db_estado != 4'd2 && n < 200);
    if (bus.db_estado != 4'd2) begin
      vectors++;
      miscompares++;
      $display("FAIL avalia_timeout: state %0d after %0d cycles, expected 2", bus.db_estado, n);
    end
  endtask

  task automatic wait_frames(input int k);
    for (int i = 0; i < k; i++) wait_avalia();
  endtask

  // Board changes land on a frame boundary; the AVALIA in progress counts as the mark.
  task automatic change(input logic [63:0] b);
    wait_avalia();
    board = b;
  endtask

  task automatic expect_pulse(input bit multi, input logic [3:0] f, input logic [3:0] c);
    exp_t e;
    e.multi = multi;
    e.f     = f;
    e.c     = c;
    e.mark  = aval_cnt + 1;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] sq(input int r, input int c);
    return 64'd1 << (r*8 + c);
  endfunction

  initial begin
    int errs;
    int wait_n;
    bus.habilita = 1'b1;
    reset        = 1'b1;
    repeat (3) @(negedge clock);

    check("rst_linhas", bus.linhas_out, 8'h01);
    check("rst_linha", bus.db_linha, 3'd0);
    check("rst_estado", bus.db_estado, 4'd1);
    check("rst_fileira", bus.jogadaFileira, 4'd0);
    check("rst_coluna", bus.jogadaColuna, 4'd0);
    check("rst_pulses", {bus.temJogada, bus.erroMulti}, 2'b00);
    reset = 1'b0;

    // Idle board: one-hot scan with SETTLE cycles per row, never EMITE.
    wait_avalia();
    errs = 0;
    for (int k = 0; k < 8*SETTLE; k++) begin
      @(negedge clock);
      if (bus.linhas_out != (8'h01 << (k / SETTLE)) || bus.db_linha != 3'(k / SETTLE)
          || bus.db_estado != 4'd1) errs++;
    end
    check("scan_sequence_errors", errs, 0);
    @(negedge clock);
    check("scan_avalia_state", bus.db_estado, 4'd2);
    check("scan_avalia_linhas", bus.linhas_out, 8'h01);
    errs = 0;
    for (int k = 0; k < 10*(8*SETTLE+1); k++) begin
      @(negedge clock);
      if (bus.db_estado != 4'd1 && bus.db_estado != 4'd2) errs++;
    end
    check("idle_states_only_1_2", errs, 0);

    // Baseline: a square held from the start only records board state.
    change(sq(1, 2));
    wait_frames(5);
    check("baseline_no_pulse", sb.size(), 0);
    change(64'd0);
    wait_frames(4);
    change(sq(4, 0));
    expect_pulse(1'b0, 4'd5, 4'd1);
    wait_frames(4);
    check("move_4_0_drained", sb.size(), 0);
    check("hold_fileira_5", bus.jogadaFileira, 4'd5);

    // Corner file H: one pulse, then a long hold produces nothing more.
    change(64'd0);
    wait_frames(4);
    change(sq(6, 7));
    expect_pulse(1'b0, 4'd7, 4'd8);
    wait_frames(4);
    check("move_6_7_drained", sb.size(), 0);
    wait_frames(10);
    check("hold_coluna_8", bus.jogadaColuna, 4'd8);

    // Bounce: alternate for four frames, then hold.
    change(64'd0);
    wait_frames(4);
    change(sq(2, 3));
    change(64'd0);
    change(sq(2, 3));
    change(64'd0);
    change(sq(2, 3));
    expect_pulse(1'b0, 4'd3, 4'd4);
    wait_frames(4);
    check("bounce_drained", sb.size(), 0);

    // Two new squares in one frame: error pulse, coordinates kept.
    change(64'd0);
    wait_frames(4);
    change(sq(0, 0) | sq(7, 7));
    expect_pulse(1'b1, 4'd3, 4'd4);
    wait_frames(4);
    check("multi_drained", sb.size(), 0);
    change(64'd0);
    wait_frames(4);
    check("multi_release_fileira", bus.jogadaFileira, 4'd3);
    check("multi_release_coluna", bus.jogadaColuna, 4'd4);

    // Disabled: the press is absorbed and not reported after re-enabling.
    change(sq(3, 5));
    bus.habilita = 1'b0;
    wait_frames(4);
    bus.habilita = 1'b1;
    wait_frames(4);
    check("habilita_no_backlog", sb.size(), 0);
    check("habilita_coluna_kept", bus.jogadaColuna, 4'd4);

    // Reset during row 5 of a frame carrying a new press.
    change(sq(3, 5) | sq(5, 1));
    wait_n = 0;
    do begin
      @(negedge clock);
      wait_n++;
    end while (!(bus.db_estado == 4'd1 && bus.db_linha == 3'd5) && wait_n < 200);
    check("row5_reached", bus.db_linha, 3'd5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_linhas", bus.linhas_out, 8'h01);
    check("midrst_estado", bus.db_estado, 4'd1);
    check("midrst_fileira", bus.jogadaFileira, 4'd0);
    check("midrst_coluna", bus.jogadaColuna, 4'd0);
    check("midrst_pulses", {bus.temJogada, bus.erroMulti}, 2'b00);
    reset = 1'b0;
    wait_frames(6);
    check("midrst_baseline_no_pulse", sb.size(), 0);
    change(sq(3, 5) | sq(5, 1) | sq(2, 2));
    expect_pulse(1'b0, 4'd3, 4'd3);
    wait_frames(4);
    check("post_reset_move_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/leitor_tabuleiro.md
Name: leitor_tabuleiro

Overview:
- Upstream input stage of the chess-lab game datapath.
- Scans an 8x8 matrix of square sensors (reed switches or buttons), one row at a time.
- Debounces each whole board frame, then detects a newly pressed square.
- Emits that square's rank/file together with a one-cycle temJogada pulse, which feeds the jogadaFileira/jogadaColuna/temJogada inputs of the game top level.

Parameters:
- SETTLE, 4: clock cycles each row stays driven before its columns are sampled (≥2).
- STABLE_FRAMES, 3: consecutive identical raw frames needed to accept a frame (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- habilita  in  1  when low, scanning continues but temJogada/erroMulti are suppressed
- colunas_in  in  8  column sense lines, 1 = square pressed in the driven row; bit c = file c
- linhas_out  out  8  one-hot row drive; bit r = rank r
- jogadaFileira  out  4  rank of the last detected move, 1..8
- jogadaColuna  out  4  file of the last detected move, 1..8 (1 = A)
- temJogada  out  1  one-cycle pulse, new coordinates valid
- erroMulti  out  1  one-cycle pulse, more than one new square in an accepted frame
- db_estado  out  4  FSM state code
- db_linha  out  3  index of the row currently driven

Behaviour:
- Reset values:
  - linhas_out=8'b0000_0001; row index 0; settle counter 0
  - jogadaFileira=0, jogadaColuna=0; temJogada=0, erroMulti=0
  - raw/last/accepted images all 0; stable count 0; baseline flag set; state VARRE
- Reset is honoured in any state, including mid-frame; the partial frame is discarded.
- Raw image bit index = r*8+c.
- FSM states (db_estado code):
  - VARRE (1): drive row r for SETTLE cycles. On the last dwell cycle, latch colunas_in into raw[r*8+7 : r*8].
    - r<7: advance r and the one-hot drive.
    - r=7: go to AVALIA; linhas_out returns to row 0 on the same edge.
  - AVALIA (2), one cycle:
    - raw==last: stable count increments, saturating at STABLE_FRAMES.
    - raw!=last: stable count=1, last<=raw.
    - Frame is accepted when the count reaches STABLE_FRAMES on this cycle (transition only, not while already saturated) and raw!=accepted.
    - Next state is EMITE if accepted, else VARRE.
  - EMITE (3), one cycle, with novo = raw & ~accepted:
    - baseline flag set: no pulse; clear the flag.
    - else, popcount(novo)==1 and habilita: temJogada=1; jogadaFileira=r+1, jogadaColuna=c+1 of that bit.
    - else, popcount(novo)>1 and habilita: erroMulti=1; coordinates unchanged.
    - else (novo==0, releases only): no pulse.
    - In all cases accepted<=raw; return to VARRE at row 0.
- Frame period = 8*SETTLE+1 cycles without EMITE, +1 with EMITE.
- With STABLE_FRAMES=1, every changed frame is accepted at its AVALIA (when raw!=accepted).
- Latency: temJogada is asserted on the cycle after the AVALIA of the STABLE_FRAMES-th identical frame.
- Coordinates hold until the next valid move or reset. temJogada and erroMulti are never asserted together and never last more than 1 cycle.
- Releases and multi-press frames still update accepted, so a held square never re-reports.
- habilita low discards any pulse but still updates accepted, so no backlog is produced.
- Baseline: the first accepted frame after reset only records board state, so squares already occupied at reset do not generate moves.

Decomposition:
- Shared package chess_pkg holds:
  - state encodings ST_VARRE=4'd1, ST_AVALIA=4'd2, ST_EMITE=4'd3;
  - N_LINHAS=8, N_COLUNAS=8.
- One sub-module, codificador_quadrado: combinational 64-bit novo → 3-bit row, 3-bit column, unico (popcount==1), multiplo (popcount>1).
- Scan timing and FSM stay in leitor_tabuleiro.

Test Plan (SETTLE=4, STABLE_FRAMES=3, frame ≈33 cycles):
- Reset, colunas_in=0 for 10 frames → linhas_out cycles 01,02,04…80 with 4 cycles per row; temJogada never asserted; db_estado visits 1/2 only.
- Baseline: after reset, hold square (r=1,c=2) pressed for 5 frames → no pulse. Release it, then press (r=4,c=0) → single temJogada pulse; Fileira=5, Coluna=1.
- Press (r=6,c=7) only while row 6 is driven, stable 3 frames → exactly one temJogada at the cycle after the 3rd AVALIA; Fileira=7, Coluna=8. Keep holding 10 frames → no further pulse.
- Bounce: toggle (r=2,c=3) every frame for 4 frames, then hold → pulse only after 3 identical frames; Fileira=3, Coluna=4.
- Press (r=0,c=0) and (r=7,c=7) in the same frame → erroMulti for 1 cycle, temJogada=0, coordinates unchanged; releasing both → no pulse.
- Assert reset during row 5 of a frame with a new press → outputs return to reset values next cycle, linhas_out=01, no pulse for that press (it becomes the baseline).
